// File: rtl/usb_fs_pkg.sv
// Shared types and constants for the full-speed USB transmit sequencer.
package usb_fs_pkg;

  typedef enum logic [3:0] {
    IDLE, SYNC, DATA, STUFF, ABORT, EOP_SE0, EOP_J, RESUME, RESUME_J
  } state_e;

  // {dp,dn} line levels
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam int STUFF_LIMIT  = 6;
  localparam int ABORT_BITS   = 7;
  localparam int EOP_SE0_BITS = 2;

  // NRZI: a 0 toggles between J and K, a 1 holds the current level
  function automatic logic [1:0] nrzi(input logic [1:0] lvl, input logic b);
    return b ? lvl : ((lvl == J) ? K : J);
  endfunction

endpackage

// File: rtl/usb_fs_bit_timer.sv
// Bit-time divider: counts 0..CLK_DIV-1 while running, pinned at 0 otherwise.
module usb_fs_bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic bit_tick
);

  localparam int W = $clog2(CLK_DIV);

  logic [W-1:0] cnt;

  assign bit_tick = run && (cnt == W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (!run || bit_tick) cnt <= '0;
    else                       cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/usb_fs_tx_ctrl.sv
// Full-speed USB transmitter: SYNC, NRZI + bit stuffing, EOP, resume K,
// pad enable ownership and synchronised receive line state.
module usb_fs_tx_ctrl
  import usb_fs_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int RESUME_BITS = 12000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_underrun,
  input  logic       resume_req,
  output logic       resume_ack,
  output logic       busy,
  output logic [1:0] line_state,
  output logic       usb_dp_en_o,
  output logic       usb_dn_en_o,
  output logic       usb_dp_tx_o,
  output logic       usb_dn_tx_o,
  input  logic       usb_dp_rx_i,
  input  logic       usb_dn_rx_i
);

  localparam int CW = $clog2(RESUME_BITS + ABORT_BITS) + 1;

  state_e        state, state_d;
  logic          tick;
  logic [1:0]    pad, pad_d;
  logic          en, en_d, ack_d;
  logic [7:0]    data_q, data_d, cur_data;
  logic          last_q, last_d;
  logic [3:0]    idx, idx_d, cur_idx;
  logic [2:0]    ones, ones_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          boundary, take, stuff_now, load_bit, next_bit;
  logic [1:0]    rx_meta;

  usb_fs_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (state != IDLE),
    .bit_tick (tick)
  );

  // idx is the next data bit to load; 8 means the byte is exhausted
  assign boundary    = (state == DATA) && (idx == 4'd8) && !last_q;
  assign take        = (state == IDLE) ? tx_valid : (tick && boundary && tx_valid);
  assign tx_ready    = take;
  assign tx_underrun = tick && boundary && !tx_valid;
  assign stuff_now   = (state == DATA) && (ones == 3'(STUFF_LIMIT));
  assign cur_data    = take ? tx_data : data_q;
  assign cur_idx     = take ? 4'd0 : idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:        if (tx_valid) state_d = SYNC;
                   else if (resume_req) state_d = RESUME;
      SYNC:        if (tick && idx == 4'd7) state_d = DATA;
      DATA, STUFF: if (tick) begin
                     if (tx_underrun)         state_d = ABORT;
                     else if (stuff_now)      state_d = STUFF;
                     else if (cur_idx < 4'd8) state_d = DATA;
                     else                     state_d = EOP_SE0;
                   end
      ABORT:       if (tick && cnt == CW'(ABORT_BITS - 1)) state_d = EOP_SE0;
      EOP_SE0:     if (tick && cnt == CW'(EOP_SE0_BITS - 1)) state_d = EOP_J;
      EOP_J:       if (tick) state_d = IDLE;
      RESUME:      if (tick && cnt == CW'(RESUME_BITS - 1)) state_d = RESUME_J;
      RESUME_J:    if (tick) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    pad_d    = pad;
    en_d     = en;
    ack_d    = 1'b0;
    data_d   = cur_data;
    last_d   = take ? tx_last : last_q;
    idx_d    = idx;
    ones_d   = ones;
    cnt_d    = cnt;
    load_bit = 1'b0;
    next_bit = 1'b0;
    case (state)
      IDLE: begin
        if (tx_valid) begin
          load_bit = 1'b1;
          next_bit = SYNC_PATTERN[0];
          en_d     = 1'b1;
          idx_d    = 4'd0;
        end else if (resume_req) begin
          pad_d = K;
          en_d  = 1'b1;
          cnt_d = '0;
        end
      end
      SYNC: if (tick) begin
        load_bit = 1'b1;
        if (idx == 4'd7) begin
          next_bit = data_q[0];
          idx_d    = 4'd1;
        end else begin
          next_bit = SYNC_PATTERN[3'(idx + 4'd1)];
          idx_d    = idx + 4'd1;
        end
      end
      DATA, STUFF: if (tick) begin
        if (tx_underrun) begin
          cnt_d = '0;
        end else if (stuff_now) begin
          load_bit = 1'b1;
          idx_d    = cur_idx;
        end else if (cur_idx < 4'd8) begin
          load_bit = 1'b1;
          next_bit = cur_data[cur_idx[2:0]];
          idx_d    = cur_idx + 4'd1;
        end else begin
          pad_d = SE0;
          cnt_d = '0;
        end
      end
      ABORT: if (tick) begin
        if (cnt == CW'(ABORT_BITS - 1)) begin
          pad_d = SE0;
          cnt_d = '0;
        end else cnt_d = cnt + CW'(1);
      end
      EOP_SE0: if (tick) begin
        if (cnt == CW'(EOP_SE0_BITS - 1)) pad_d = J;
        else cnt_d = cnt + CW'(1);
      end
      EOP_J: if (tick) en_d = 1'b0;
      RESUME: if (tick) begin
        if (cnt == CW'(RESUME_BITS - 1)) pad_d = J;
        else cnt_d = cnt + CW'(1);
      end
      RESUME_J: if (tick) begin
        en_d  = 1'b0;
        ack_d = 1'b1;
      end
      default: ;
    endcase
    if (load_bit) begin
      pad_d  = nrzi(pad, next_bit);
      ones_d = next_bit ? ones + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad        <= J;
      en         <= 1'b0;
      resume_ack <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      idx        <= '0;
      ones       <= '0;
      cnt        <= '0;
      rx_meta    <= '0;
      line_state <= '0;
    end else begin
      pad        <= pad_d;
      en         <= en_d;
      resume_ack <= ack_d;
      data_q     <= data_d;
      last_q     <= last_d;
      idx        <= idx_d;
      ones       <= ones_d;
      cnt        <= cnt_d;
      rx_meta    <= {usb_dp_rx_i, usb_dn_rx_i};
      line_state <= rx_meta;
    end
  end

  assign busy        = (state != IDLE);
  assign usb_dp_en_o = en;
  assign usb_dn_en_o = en;
  assign usb_dp_tx_o = pad[1];
  assign usb_dn_tx_o = pad[0];

endmodule
